// File: rtl/scalar_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scalar_wb_arbiter
// Purpose  : Round-robin arbiter that shares the scalar register-file write
//            port among NUM_REQ writeback requesters. It uses valid/ready
//            handshakes into a one-entry registered output stage with
//            back-pressure. Writes to x0 are dropped, and writes to the
//            execution-mask register are dropped unless they come from the
//            vector-to-scalar path.
// Option   : SCALAR_WB_STATS_EN adds the grant_count_o and blocked_count_o
//            saturating statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module scalar_wb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MASK_REG   = 31,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd_address_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]               req_is_v2s_i,
    output logic                             wr_valid_o,
    input  logic                             wr_ready_i,
    output logic [ADDR_WIDTH-1:0]            wr_address_o,
    output logic [DATA_WIDTH-1:0]            wr_data_o,
    output logic [SRC_W-1:0]                 wr_src_o,
`ifdef SCALAR_WB_STATS_EN
    output logic [NUM_REQ*16-1:0]            grant_count_o,
    output logic [15:0]                      blocked_count_o,
`endif
    output logic                             blocked_pulse_o
);

    localparam logic [ADDR_WIDTH-1:0] C_MASK_ADDR = ADDR_WIDTH'(MASK_REG);
    localparam logic [SRC_W-1:0]      C_LAST_IDX  = SRC_W'(NUM_REQ - 1);

    logic [SRC_W-1:0]      rr_ptr_q,        rr_ptr_d;
    logic                  wr_valid_q,      wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_address_q,    wr_address_d;
    logic [DATA_WIDTH-1:0] wr_data_q,       wr_data_d;
    logic [SRC_W-1:0]      wr_src_q,        wr_src_d;
    logic                  blocked_pulse_q, blocked_pulse_d;

    logic                  w_free;
    logic                  w_found;
    logic                  w_grant;
    logic                  w_blocked;
    logic [SRC_W-1:0]      w_grant_idx;
    logic [ADDR_WIDTH-1:0] w_grant_addr;
    logic [DATA_WIDTH-1:0] w_grant_data;

    // Rotating priority search starting at rr_ptr. The loop runs from the
    // farthest offset down, so the nearest valid requester is assigned last
    // and wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid_i[idx]) begin
                w_found     = 1'b1;
                w_grant_idx = SRC_W'(idx);
            end
        end
        // A grant is made only when the output stage can take a new command
        // this cycle. While reset is asserted, no request is accepted.
        w_free       = !wr_valid_q || wr_ready_i;
        w_grant      = w_found && w_free && !reset;
        w_grant_addr = req_rd_address_i[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        w_grant_data = req_data_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
        w_blocked    = (w_grant_addr == '0) ||
                       ((w_grant_addr == C_MASK_ADDR) && !req_is_v2s_i[w_grant_idx]);
        req_ready_o  = w_grant ? (NUM_REQ'(1) << w_grant_idx) : '0;
    end

    // Next state of the output stage and the round-robin pointer. A blocked
    // grant still consumes the request but loads nothing into the stage.
    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        wr_valid_d      = wr_valid_q;
        wr_address_d    = wr_address_q;
        wr_data_d       = wr_data_q;
        wr_src_d        = wr_src_q;
        blocked_pulse_d = w_grant && w_blocked;
        if (w_grant) begin
            rr_ptr_d = (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + 1'b1;
        end
        if (w_free) begin
            wr_valid_d = w_grant && !w_blocked;
        end
        if (w_grant && !w_blocked) begin
            wr_address_d = w_grant_addr;
            wr_data_d    = w_grant_data;
            wr_src_d     = w_grant_idx;
        end
    end

    // State registers. Reset discards any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q        <= '0;
            wr_valid_q      <= 1'b0;
            wr_address_q    <= '0;
            wr_data_q       <= '0;
            wr_src_q        <= '0;
            blocked_pulse_q <= 1'b0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            wr_valid_q      <= wr_valid_d;
            wr_address_q    <= wr_address_d;
            wr_data_q       <= wr_data_d;
            wr_src_q        <= wr_src_d;
            blocked_pulse_q <= blocked_pulse_d;
        end
    end

    assign wr_valid_o      = wr_valid_q;
    assign wr_address_o    = wr_address_q;
    assign wr_data_o       = wr_data_q;
    assign wr_src_o        = wr_src_q;
    assign blocked_pulse_o = blocked_pulse_q;

`ifdef SCALAR_WB_STATS_EN
    logic [15:0] blocked_count_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        logic [15:0] cnt_q;
        // Per-requester acceptance counter. It counts blocked grants too,
        // and it saturates at its maximum value.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (req_ready_o[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign grant_count_o[gi*16 +: 16] = cnt_q;
    end

    // Saturating count of grants discarded by register protection.
    always_ff @(posedge clk) begin
        if (reset) begin
            blocked_count_q <= '0;
        end else if (w_grant && w_blocked && (blocked_count_q != 16'hFFFF)) begin
            blocked_count_q <= blocked_count_q + 16'd1;
        end
    end
    assign blocked_count_o = blocked_count_q;
`endif

endmodule
`default_nettype wire
